// File: rtl/arbitro_pkg.sv
// Shared types for the memory arbiter: FSM state encoding and port-owner codes.
package arbitro_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

endpackage

// File: rtl/arbitro_prio.sv
// Winner selection between the fetch and data ports.
// Build option: define ARB_ROUND_ROBIN_EN to alternate the winner on conflicts;
// otherwise the data port always wins a conflict.
module arbitro_prio
    import arbitro_pkg::*;
(
    input  logic req_if,
    input  logic req_dm,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic last_owner,
`endif
    output logic grant,
    output logic owner
);

    // Combinational choice of the winning port from the already-masked requests.
    always_comb begin
        // NOTE: every output gets a default first so no path through the block infers a latch.
        grant = req_if | req_dm;
        owner = OWN_IF;
        if (req_if && req_dm) begin
`ifdef ARB_ROUND_ROBIN_EN
            owner = (last_owner == OWN_IF) ? OWN_DM : OWN_IF;
`else
            owner = OWN_DM;
`endif
        end else if (req_dm) begin
            owner = OWN_DM;
        end
    end

endmodule

// File: rtl/arbitro_memoria.sv
// Arbiter serializing the CPU fetch and data ports onto one shared memory port.
// Each transaction runs IDLE -> ISSUE -> RESP, acking the owner one cycle later.
// Build option: ARB_ROUND_ROBIN_EN selects alternating conflict resolution
// instead of fixed data-port priority.
module arbitro_memoria
    import arbitro_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    output logic          if_stall,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ack,
    output logic          dm_stall,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_t        state;
    logic          owner_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          if_ack_q;
    logic          dm_ack_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] dm_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    logic          last_owner;
`endif

    logic req_if_m;
    logic req_dm_m;
    logic grant;
    logic grant_owner;

    // A port still showing its ack is ignored so a held request is not re-served at once.
    assign req_if_m = if_req & ~if_ack_q;
    assign req_dm_m = dm_req & ~dm_ack_q;

    arbitro_prio u_prio (
        .req_if     (req_if_m),
        .req_dm     (req_dm_m),
`ifdef ARB_ROUND_ROBIN_EN
        .last_owner (last_owner),
`endif
        .grant      (grant),
        .owner      (grant_owner)
    );

    // Transaction FSM: latch the winner in IDLE, strobe memory in ISSUE, complete in RESP.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner <= OWN_IF;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner_q <= grant_owner;
                        if (grant_owner == OWN_DM) begin
                            addr_q  <= dm_addr;
                            we_q    <= dm_we;
                            wdata_q <= dm_wdata;
                        end else begin
                            addr_q  <= if_addr;
                            we_q    <= 1'b0;
                            wdata_q <= '0;
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        last_owner <= grant_owner;
`endif
                        state <= ISSUE;
                    end
                end
                ISSUE: state <= RESP;
                RESP: begin
                    if (owner_q == OWN_DM) begin
                        dm_ack_q <= 1'b1;
                        if (!we_q) dm_rdata_q <= mem_rdata;
                    end else begin
                        if_ack_q <= 1'b1;
                        if (!we_q) if_rdata_q <= mem_rdata;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory strobe only in ISSUE, and never while reset is asserted.
    assign mem_en    = (state == ISSUE) & ~reset;
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign if_ack   = if_ack_q;
    assign dm_ack   = dm_ack_q;
    assign if_rdata = if_rdata_q;
    assign dm_rdata = dm_rdata_q;

    // Stalls follow the live request and ack in the same cycle.
    assign if_stall = if_req & ~if_ack_q;
    assign dm_stall = dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_arbitro_memoria.sv
// Self-checking bench for arbitro_memoria: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference model.
module tb_arbitro_memoria;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    logic        clock = 1'b0;
    logic        reset, if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_ack, if_stall, dm_ack, dm_stall, mem_en, mem_we;
    logic [31:0] mem_rdata = '0;

    arbitro_memoria dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .if_stall  (if_stall),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ack    (dm_ack),
        .dm_stall  (dm_stall),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_default(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Shared memory stub: 64 words, read data one cycle after the strobe.
    logic [31:0] tb_mem [64];
    logic        mem_init_done = 1'b0;
    always @(posedge clock) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= mem_default(32'(i) << 2);
            tb_mem[4] <= 32'h2008_0005;
            mem_init_done <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) tb_mem[mem_addr[7:2]] <= mem_wdata;
            else        mem_rdata <= tb_mem[mem_addr[7:2]];
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Stimulus for the current cycle.
    logic        s_reset = 1'b1, s_if_req = 1'b0, s_dm_req = 1'b0, s_dm_we = 1'b0;
    logic [31:0] s_if_addr = '0, s_dm_addr = '0, s_dm_wdata = '0;

    // Reference model: one transaction at a time, acked three cycles after acceptance.
    int unsigned cyc = 0;
    int unsigned free_at = 0;
    int unsigned acc_cyc = 0;
    bit          busy = 0, rst_pending = 0;
    logic        acc_port = OWN_IF, acc_we = 1'b0, last_port = OWN_IF;
    logic [31:0] acc_addr = '0, acc_wdata = '0, acc_rdata = '0;
    logic [31:0] lat_addr = '0, lat_wdata = '0;
    logic        exp_if_ack = 0, exp_dm_ack = 0, exp_mem_en = 0, exp_mem_we = 0;
    logic [31:0] exp_if_rdata = '0, exp_dm_rdata = '0;
    logic [31:0] ref_mem [64];

    task automatic model_cycle();
        logic m_if, m_dm, win;
        if (s_reset) begin
            rst_pending = 1;
            return;
        end
        if (busy && cyc == acc_cyc + 1) begin
            if (acc_we) ref_mem[acc_addr[7:2]] = acc_wdata;
            else        acc_rdata = ref_mem[acc_addr[7:2]];
        end
        if (cyc >= free_at) begin
            m_if = s_if_req && !exp_if_ack;
            m_dm = s_dm_req && !exp_dm_ack;
            if (m_if || m_dm) begin
                if (m_if && m_dm) begin
`ifdef ARB_ROUND_ROBIN_EN
                    win = (last_port == OWN_IF) ? OWN_DM : OWN_IF;
`else
                    win = OWN_DM;
`endif
                end else begin
                    win = m_dm ? OWN_DM : OWN_IF;
                end
                busy      = 1;
                acc_cyc   = cyc;
                acc_port  = win;
                acc_we    = (win == OWN_DM) ? s_dm_we : 1'b0;
                acc_addr  = (win == OWN_DM) ? s_dm_addr : s_if_addr;
                acc_wdata = (win == OWN_DM) ? s_dm_wdata : 32'h0;
                last_port = win;
                free_at   = cyc + 3;
            end
        end
    endtask

    task automatic model_advance();
        exp_if_ack = 0;
        exp_dm_ack = 0;
        exp_mem_en = 0;
        exp_mem_we = 0;
        if (rst_pending) begin
            rst_pending  = 0;
            busy         = 0;
            free_at      = cyc;
            exp_if_rdata = '0;
            exp_dm_rdata = '0;
            lat_addr     = '0;
            lat_wdata    = '0;
            last_port    = OWN_IF;
            return;
        end
        if (busy && cyc == acc_cyc + 1) begin
            exp_mem_en = 1;
            exp_mem_we = acc_we;
            lat_addr   = acc_addr;
            lat_wdata  = acc_wdata;
        end
        if (busy && cyc == acc_cyc + 3) begin
            busy = 0;
            if (acc_port == OWN_DM) begin
                exp_dm_ack = 1;
                if (!acc_we) exp_dm_rdata = acc_rdata;
            end else begin
                exp_if_ack = 1;
                if (!acc_we) exp_if_rdata = acc_rdata;
            end
        end
    endtask

    // Apply stimulus for one cycle, check everything, and move to the next cycle.
    task automatic tick();
        reset    = s_reset;
        if_req   = s_if_req;
        if_addr  = s_if_addr;
        dm_req   = s_dm_req;
        dm_we    = s_dm_we;
        dm_addr  = s_dm_addr;
        dm_wdata = s_dm_wdata;
        #1;
        check("if_stall", 32'(if_stall), 32'(s_if_req & ~exp_if_ack));
        check("dm_stall", 32'(dm_stall), 32'(s_dm_req & ~exp_dm_ack));
        check("mem_en",   32'(mem_en),   32'(exp_mem_en & ~s_reset));
        check("mem_we",   32'(mem_we),   32'(exp_mem_we & ~s_reset));
        model_cycle();
        @(posedge clock);
        #1;
        cyc++;
        model_advance();
        check("if_ack",    32'(if_ack), 32'(exp_if_ack));
        check("dm_ack",    32'(dm_ack), 32'(exp_dm_ack));
        check("if_rdata",  if_rdata,  exp_if_rdata);
        check("dm_rdata",  dm_rdata,  exp_dm_rdata);
        check("mem_addr",  mem_addr,  lat_addr);
        check("mem_wdata", mem_wdata, lat_wdata);
    endtask

    function automatic logic [31:0] rand_addr();
        return {24'h0, 6'($urandom_range(0, 63)), 2'b00};
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = mem_default(32'(i) << 2);
        ref_mem[4] = 32'h2008_0005;

        // Reset state.
        s_reset = 1'b1;
        repeat (3) tick();
        s_reset = 1'b0;
        check("rst_if_ack",   32'(if_ack), 32'h0);
        check("rst_dm_ack",   32'(dm_ack), 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_dm_rdata", dm_rdata, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        tick();

        // Fetch only.
        s_if_req = 1'b1; s_if_addr = 32'h10;
        tick();
        check("fetch_mem_en",   32'(mem_en), 32'h1);
        check("fetch_mem_addr", mem_addr, 32'h10);
        tick(); tick();
        check("fetch_ack",   32'(if_ack), 32'h1);
        check("fetch_rdata", if_rdata, 32'h2008_0005);
        s_if_req = 1'b0;
        tick();

        // Store then load with the request held through the store ack.
        s_dm_req = 1'b1; s_dm_we = 1'b1; s_dm_addr = 32'h40; s_dm_wdata = 32'hDEAD_BEEF;
        tick();
        check("store_mem_we", 32'(mem_we), 32'h1);
        tick();
        check("store_we_off", 32'(mem_we), 32'h0);
        tick();
        check("store_ack", 32'(dm_ack), 32'h1);
        s_dm_we = 1'b0; s_dm_wdata = 32'h0;
        tick();
        check("load_masked", 32'(mem_en), 32'h0);
        tick();
        check("load_issue", 32'(mem_en), 32'h1);
        tick(); tick();
        check("load_ack",   32'(dm_ack), 32'h1);
        check("load_rdata", dm_rdata, 32'hDEAD_BEEF);
        s_dm_req = 1'b0;
        tick();

        // Simultaneous requests.
        s_if_req = 1'b1; s_if_addr = 32'h4; s_dm_req = 1'b1; s_dm_addr = 32'h80;
        tick();
        check("conf_first_addr", mem_addr, 32'h80);
        tick(); tick();
        check("conf_dm_ack", 32'(dm_ack), 32'h1);
        check("conf_if_wait", 32'(if_ack), 32'h0);
        s_dm_req = 1'b0;
        tick();
        check("conf_if_addr", mem_addr, 32'h4);
        tick(); tick();
        check("conf_if_ack", 32'(if_ack), 32'h1);
        s_if_req = 1'b0;
        tick();
        s_if_req = 1'b1; s_dm_req = 1'b1;
        tick();
        check("conf3_winner", mem_addr, 32'h80);
        tick(); tick();
        s_if_req = 1'b0; s_dm_req = 1'b0;
        tick();
        s_if_req = 1'b1; s_dm_req = 1'b1;
        tick();
`ifdef ARB_ROUND_ROBIN_EN
        check("conf4_winner", mem_addr, 32'h4);
`else
        check("conf4_winner", mem_addr, 32'h80);
`endif
        tick(); tick();
        s_if_req = 1'b0; s_dm_req = 1'b0;
        tick();

        // Reset during the ISSUE cycle of a write.
        s_dm_req = 1'b1; s_dm_we = 1'b1; s_dm_addr = 32'h44; s_dm_wdata = 32'h1234_5678;
        tick();
        check("rst_issue_en", 32'(mem_en), 32'h1);
        s_reset = 1'b1; s_dm_req = 1'b0; s_dm_we = 1'b0;
        tick();
        s_reset = 1'b0;
        check("rst_abort_en",   32'(mem_en), 32'h0);
        check("rst_abort_addr", mem_addr, 32'h0);
        repeat (3) begin
            tick();
            check("rst_no_ack", 32'(dm_ack), 32'h0);
        end
        check("rst_no_write", tb_mem[17], mem_default(32'h44));

        // Randomized traffic with occasional resets.
        repeat (3000) begin
            s_reset = ($urandom_range(0, 199) == 0);
            if (s_if_req && if_ack) begin
                if ($urandom_range(0, 2) == 0) s_if_addr = rand_addr();
                else                           s_if_req = 1'b0;
            end else if (!s_if_req) begin
                if ($urandom_range(0, 1) == 1) begin
                    s_if_req = 1'b1;
                    s_if_addr = rand_addr();
                end
            end else if ($urandom_range(0, 15) == 0) begin
                s_if_req = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                s_if_addr = rand_addr();
            end
            if (s_dm_req && dm_ack) begin
                if ($urandom_range(0, 2) == 0) begin
                    s_dm_addr  = rand_addr();
                    s_dm_we    = ($urandom_range(0, 1) == 1);
                    s_dm_wdata = $urandom;
                end else begin
                    s_dm_req = 1'b0;
                end
            end else if (!s_dm_req) begin
                if ($urandom_range(0, 1) == 1) begin
                    s_dm_req   = 1'b1;
                    s_dm_addr  = rand_addr();
                    s_dm_we    = ($urandom_range(0, 1) == 1);
                    s_dm_wdata = $urandom;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                s_dm_req = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                s_dm_addr  = rand_addr();
                s_dm_wdata = $urandom;
            end
            if (s_reset) begin
                s_if_req = 1'b0;
                s_dm_req = 1'b0;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
